// File: rtl/gamepad_pkg.sv
// Shared constants for the gamepad receiver: frame length, SNES bit positions and frame FSM states.
package gamepad_pkg;
  localparam int NUM_BITS_DEF = 12;

  // Bit positions in the held frame; the first bit shifted in ends up in the MSB.
  localparam int BTN_B     = 11;
  localparam int BTN_Y     = 10;
  localparam int BTN_SEL   = 9;
  localparam int BTN_START = 8;
  localparam int BTN_UP    = 7;
  localparam int BTN_DOWN  = 6;
  localparam int BTN_LEFT  = 5;
  localparam int BTN_RIGHT = 4;
  localparam int BTN_A     = 3;
  localparam int BTN_X     = 2;
  localparam int BTN_L     = 1;
  localparam int BTN_R     = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCHED = 2'd1,
    ST_SHIFT   = 2'd2
  } frame_state_e;
endpackage

// File: rtl/gamepad_receiver_pmod_sync.sv
// Synchroniser chain for one PMOD input, with rise/fall strobes taken from the synchronised level.
module pmod_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;
endmodule

// File: rtl/gamepad_receiver.sv
// Gamepad PMOD deserialiser: validates frames and presents button levels updated once per frame_tick.
// Optional GAMEPAD_ONEHOT_DIR_EN: resolve directions to one-hot with priority up > down > left > right.
module gamepad_receiver
  import gamepad_pkg::*;
#(
  parameter int NUM_BITS    = NUM_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pmod_latch,
  input  logic pmod_clk,
  input  logic pmod_data,
  input  logic frame_tick,
  output logic A,
  output logic B,
  output logic select,
  output logic start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic pressed_ab,
  output logic present,
  output logic frame_error
);
  localparam int CW = $clog2(NUM_BITS + 2);

  logic latch_level, latch_rise, latch_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic data_level, data_rise, data_fall;

  pmod_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .clk(clk), .reset(reset), .din(pmod_latch),
    .level(latch_level), .rise(latch_rise), .fall(latch_fall));
  pmod_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .reset(reset), .din(pmod_clk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
  pmod_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .reset(reset), .din(pmod_data),
    .level(data_level), .rise(data_rise), .fall(data_fall));

  frame_state_e         state, state_nxt;
  logic [NUM_BITS-1:0]  shift_reg, hold_reg;
  logic [CW-1:0]        bit_cnt;
  logic                 hold_valid;
  logic                 shift_en, commit, drop;

  // A bit clock arriving with the latch rise belongs to no frame.
  assign shift_en = sclk_rise & ~latch_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    drop      = 1'b0;
    case (state)
      ST_IDLE:    if (latch_rise) state_nxt = ST_LATCHED;
      ST_LATCHED, ST_SHIFT: begin
        if (latch_fall) begin
          state_nxt = ST_IDLE;
          commit    = (bit_cnt == CW'(NUM_BITS));
          drop      = (bit_cnt != CW'(NUM_BITS));
        end else if (latch_rise) begin
          state_nxt = ST_LATCHED;
        end else if (shift_en) begin
          state_nxt = ST_SHIFT;
        end
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      hold_reg    <= '0;
      hold_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (shift_en) shift_reg <= {shift_reg[NUM_BITS-2:0], data_level};
      if (latch_rise)
        bit_cnt <= '0;
      else if (shift_en && bit_cnt != CW'(NUM_BITS + 1))
        bit_cnt <= bit_cnt + 1'b1;
      if (commit) begin
        hold_reg   <= shift_reg;
        hold_valid <= 1'b1;
      end
      if (drop) frame_error <= 1'b1;
    end
  end

  // All-ones is what an unplugged pad reads back (pull-ups on the data line).
  logic vis, ab_nxt, up_nxt, down_nxt, left_nxt, right_nxt;
  assign vis    = hold_valid & ~(&hold_reg);
  assign ab_nxt = vis & (hold_reg[BTN_A] | hold_reg[BTN_B]);

`ifdef GAMEPAD_ONEHOT_DIR_EN
  assign up_nxt    = vis & hold_reg[BTN_UP];
  assign down_nxt  = vis & hold_reg[BTN_DOWN] & ~hold_reg[BTN_UP];
  assign left_nxt  = vis & hold_reg[BTN_LEFT] & ~hold_reg[BTN_UP] & ~hold_reg[BTN_DOWN];
  assign right_nxt = vis & hold_reg[BTN_RIGHT] & ~hold_reg[BTN_UP] & ~hold_reg[BTN_DOWN]
                   & ~hold_reg[BTN_LEFT];
`else
  assign up_nxt    = vis & hold_reg[BTN_UP];
  assign down_nxt  = vis & hold_reg[BTN_DOWN];
  assign left_nxt  = vis & hold_reg[BTN_LEFT];
  assign right_nxt = vis & hold_reg[BTN_RIGHT];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {A, B, select, start, up, down, left, right} <= '0;
      pressed_ab <= 1'b0;
      present    <= 1'b0;
    end else begin
      pressed_ab <= frame_tick & ab_nxt & ~(A | B);
      if (frame_tick) begin
        A       <= vis & hold_reg[BTN_A];
        B       <= vis & hold_reg[BTN_B];
        select  <= vis & hold_reg[BTN_SEL];
        start   <= vis & hold_reg[BTN_START];
        up      <= up_nxt;
        down    <= down_nxt;
        left    <= left_nxt;
        right   <= right_nxt;
        present <= vis;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{sclk_level, sclk_fall, data_rise, data_fall, latch_level,
                       hold_reg[BTN_Y], hold_reg[BTN_X], hold_reg[BTN_L], hold_reg[BTN_R]};
endmodule

// File: tb/tb_gamepad_receiver.sv
// Randomised bench for gamepad_receiver against a frame-level behavioural model.
module tb_gamepad_receiver;
  logic clk = 1'b0;
  logic reset, pmod_latch, pmod_clk, pmod_data, frame_tick;
  logic A, B, select, start, up, down, left, right, pressed_ab, present, frame_error;

  gamepad_receiver dut (
    .clk(clk), .reset(reset), .pmod_latch(pmod_latch), .pmod_clk(pmod_clk),
    .pmod_data(pmod_data), .frame_tick(frame_tick), .A(A), .B(B), .select(select),
    .start(start), .up(up), .down(down), .left(left), .right(right),
    .pressed_ab(pressed_ab), .present(present), .frame_error(frame_error));

  always #5 clk = ~clk;

  int cmp = 0, mis = 0;
  bit quiet = 1'b0;

  // model: last good frame, sticky error, and the levels that must be on the outputs
  logic [11:0] m_hold;
  bit          m_valid, m_err, m_prev_ab;
  logic [7:0]  e_btn;  // {A,B,select,start,up,down,left,right}
  bit          e_pab, e_present;
  bit          seen_pab;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && quiet)
      check("outputs", {21'd0, A, B, select, start, up, down, left, right, pressed_ab, present,
                        frame_error},
            {21'd0, e_btn, e_pab, e_present, m_err});
  end

  task automatic model_clear();
    m_hold = '0; m_valid = 0; m_err = 0; m_prev_ab = 0;
    e_btn = '0; e_pab = 0; e_present = 0;
  endtask

  task automatic model_tick();
    bit vis, u, d, l, r, ab;
    vis = m_valid && (m_hold != 12'hFFF);
    u = vis && m_hold[7]; d = vis && m_hold[6]; l = vis && m_hold[5]; r = vis && m_hold[4];
`ifdef GAMEPAD_ONEHOT_DIR_EN
    if (u) begin d = 0; l = 0; r = 0; end
    else if (d) begin l = 0; r = 0; end
    else if (l) r = 0;
`endif
    ab = vis && (m_hold[3] || m_hold[11]);
    e_btn = {vis && m_hold[3], vis && m_hold[11], vis && m_hold[9], vis && m_hold[8], u, d, l, r};
    e_present = vis;
    e_pab = ab && !m_prev_ab;
    m_prev_ab = ab;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; pmod_latch = 0; pmod_clk = 0; pmod_data = 0; frame_tick = 0;
    model_clear();
    cyc(3);
    reset = 0;
    cyc(3);
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1;
    @(posedge clk); #1 model_tick();
    @(negedge clk) begin seen_pab = pressed_ab; frame_tick = 0; end
    @(posedge clk); #1 e_pab = 0;
  endtask

  // Clocks n bits MSB-first between latch rise and fall. With coinc set, a tick is
  // placed on the cycle the receiver commits the frame.
  task automatic send_frame(input logic [12:0] bits, input int n, input bit coinc);
    if (n != 12) quiet = 0;
    @(negedge clk) pmod_latch = 1;
    cyc(4);
    for (int i = n - 1; i >= 0; i--) begin
      pmod_data = bits[i];
      cyc(3); pmod_clk = 1;
      cyc(3); pmod_clk = 0;
    end
    cyc(3);
    pmod_latch = 0; pmod_data = 0;
    if (coinc) begin
      cyc(2);
      frame_tick = 1;
      @(posedge clk); #1 model_tick();
      @(negedge clk) begin seen_pab = pressed_ab; frame_tick = 0; end
      @(posedge clk); #1 e_pab = 0;
      cyc(4);
    end else begin
      cyc(6);
    end
    if (n == 12) begin m_hold = bits[11:0]; m_valid = 1; end
    else m_err = 1;
    quiet = 1;
  endtask

  initial begin
    logic [12:0] rb;
    int nb, r;
    do_reset();
    quiet = 1;
    cyc(1);
    check("reset_outputs", {A, B, select, start, up, down, left, right, pressed_ab, present,
                            frame_error}, 0);

    // first tick after reset: nothing captured yet
    tick();
    check("no_frame_present", present, 0);

    // UP only
    send_frame(13'b0_0000_1000_0000, 12, 0); tick();
    check("t1_up", {up, down, left, right, A, B, select, start}, 8'b1000_0000);
    check("t1_present", present, 1);

    // disconnected pad
    send_frame(13'h0FFF, 12, 0); tick();
    check("t2_present", present, 0);
    check("t2_buttons", {up, down, left, right, A, B, select, start}, 0);
    check("t2_no_error", frame_error, 0);

    // A-only: pulse on first tick, not on second; release then press pulses again
    send_frame(13'h0008, 12, 0); tick();
    check("t4_pab_first", seen_pab, 1);
    tick();
    check("t4_pab_second", seen_pab, 0);
    send_frame(13'h0000, 12, 0); tick();
    send_frame(13'h0008, 12, 0); tick();
    check("t4_pab_again", seen_pab, 1);

    // UP+LEFT+RIGHT
    send_frame(13'h00B0, 12, 0); tick();
`ifdef GAMEPAD_ONEHOT_DIR_EN
    check("t5_dirs", {up, down, left, right}, 4'b1000);
`else
    check("t5_dirs", {up, down, left, right}, 4'b1011);
`endif

    // DOWN shown, then LEFT frame commits on the tick cycle
    send_frame(13'h0040, 12, 0); tick();
    send_frame(13'h0020, 12, 1);
    check("t6_old_levels", {up, down, left, right}, 4'b0100);
    tick();
    check("t6_new_levels", {up, down, left, right}, 4'b0010);

    // short frame: sticky error, levels unchanged
    send_frame(13'h0123, 11, 0); tick();
    check("t3_error", frame_error, 1);
    check("t3_levels", {up, down, left, right}, 4'b0010);

    // reset during a partial frame
    @(negedge clk) pmod_latch = 1;
    cyc(4);
    repeat (5) begin pmod_data = 1; cyc(3); pmod_clk = 1; cyc(3); pmod_clk = 0; end
    quiet = 0;
    reset = 1; pmod_latch = 0; pmod_data = 0; model_clear();
    cyc(3); reset = 0; cyc(6);
    quiet = 1;
    check("mid_reset_no_error", frame_error, 0);
    send_frame(13'h0100, 12, 0); tick();
    check("after_reset_start", start, 1);

    for (int it = 0; it < 40; it++) begin
      r  = $urandom_range(0, 11);
      nb = (r == 0) ? 11 : (r == 1) ? 13 : 12;
      rb = 13'($urandom);
      if (r == 2) rb = 13'h0FFF;
      send_frame(rb, nb, (r == 3));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: run did not complete, compared %0d", cmp);
    $fatal(1, "timeout");
  end
endmodule
